// File: rtl/pad_frame_scheduler_pkg.sv
// Shared constants and state encoding for the feature-padding frame scheduler.
// Also used by the padding stage for its padded-frame and interior-pixel sizes.
package pad_frame_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFETCH,
        S_RUN,
        S_PASS_END,
        S_DONE
    } sched_state_t;

    localparam int IMG_W_DEF = 32;
    localparam int IMG_H_DEF = 32;

    function automatic int padded_size(input int w, input int h);
        return (w + 2) * (h + 2);
    endfunction

    function automatic int pixel_count(input int w, input int h);
        return w * h;
    endfunction

    localparam int PAD_FRAME_SIZE = padded_size(IMG_W_DEF, IMG_H_DEF);
    localparam int INTERIOR_PIX   = pixel_count(IMG_W_DEF, IMG_H_DEF);

endpackage

// File: rtl/pad_frame_scheduler_prefetch_fifo.sv
// pad_prefetch_fifo: 2-entry synchronous FIFO between image RAM and padding stage.
// Ports: s_clk, s_rst (async high), push/push_data, pop, count (0..2), head.
module pad_prefetch_fifo #(
    parameter int W = 24
) (
    input  logic         s_clk,
    input  logic         s_rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: rtl/pad_frame_scheduler.sv
// pad_frame_scheduler: streams the image RAM in raster order through a 2-entry
// prefetch FIFO to the padding stage, replaying the frame NUM_PASS times.
// Ports: s_clk/s_rst, start/busy/done, pe_stall, ready4data, pad_data_req,
// pad_data_valid/pad_data, pad_out_valid, ram_rd_en/addr/data, pass_idx.
// Option SCHED_PERF_CNT_EN adds stall_cycles (RUN cycles lost to stall/underflow).
module pad_frame_scheduler
    import pad_frame_scheduler_pkg::*;
#(
    parameter int IMG_W    = 32,
    parameter int IMG_H    = 32,
    parameter int PIX_W    = 24,
    parameter int ADDR_W   = 10,
    parameter int NUM_PASS = 4,
    parameter int CNT_W    = 12
) (
    input  logic              s_clk,
    input  logic              s_rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              pe_stall,
    output logic              ready4data,
    input  logic              pad_data_req,
    output logic              pad_data_valid,
    output logic [PIX_W-1:0]  pad_data,
    input  logic              pad_out_valid,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [PIX_W-1:0]  ram_rd_data,
    output logic [2:0]        pass_idx
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int NPIX = pixel_count(IMG_W, IMG_H);
    localparam int NPAD = padded_size(IMG_W, IMG_H);

    localparam logic [ADDR_W:0]   NPIX_C   = (ADDR_W+1)'(NPIX);
    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(NPIX - 1);
    localparam logic [CNT_W-1:0]  LAST_PAD = CNT_W'(NPAD - 1);
    localparam logic [2:0]        LAST_P   = 3'(NUM_PASS - 1);

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   issued;
    logic [CNT_W-1:0]  padded_cnt;
    logic              rd_pend;
    logic [1:0]        fifo_count;
    logic [PIX_W-1:0]  fifo_head;
    logic [2:0]        occupancy;
    logic              active;
    logic              rd_issue;
    logic              fifo_pop;
    logic              beat;
    logic              last_beat;
    logic              last_pass;

    // A read counts against FIFO space from issue, so the FIFO never overflows.
    assign occupancy  = {1'b0, fifo_count} + {2'b00, rd_pend};
    assign active     = (state == S_PREFETCH) || (state == S_RUN);
    assign rd_issue   = active && (occupancy < 3'd2) && (issued != NPIX_C);

    assign busy           = (state != S_IDLE);
    assign done           = (state == S_DONE);
    assign ready4data     = (state == S_RUN) && !pe_stall;
    assign pad_data_valid = (state == S_RUN) && (fifo_count != 2'd0);
    assign pad_data       = fifo_head;
    assign ram_rd_en      = rd_issue;
    assign ram_rd_addr    = rd_addr;

    assign fifo_pop  = pad_data_req && pad_data_valid && ready4data;
    assign beat      = pad_out_valid && ready4data;
    assign last_beat = beat && (padded_cnt == LAST_PAD);
    assign last_pass = (pass_idx == LAST_P);

    pad_prefetch_fifo #(
        .W(PIX_W)
    ) u_fifo (
        .s_clk     (s_clk),
        .s_rst     (s_rst),
        .push      (rd_pend),
        .push_data (ram_rd_data),
        .pop       (fifo_pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:     if (start) state_nxt = S_PREFETCH;
            S_PREFETCH: if (fifo_count == 2'd2) state_nxt = S_RUN;
            S_RUN:      if (last_beat) state_nxt = S_PASS_END;
            S_PASS_END: begin
                if (last_pass) begin
                    state_nxt = S_DONE;
                end else if (fifo_count == 2'd2) begin
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_PREFETCH;
                end
            end
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state      <= S_IDLE;
            rd_addr    <= '0;
            issued     <= '0;
            padded_cnt <= '0;
            rd_pend    <= 1'b0;
            pass_idx   <= 3'd0;
        end else begin
            state   <= state_nxt;
            rd_pend <= rd_issue;
            if (rd_issue) begin
                issued <= issued + (ADDR_W+1)'(1);
                if (rd_addr != LAST_A) begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                end
            end
            if (beat) begin
                padded_cnt <= padded_cnt + CNT_W'(1);
            end
            // Neither reads nor beats happen in these states, so the
            // clears below never collide with the increments above.
            if (state == S_PASS_END || state == S_DONE ||
                (state == S_IDLE && start)) begin
                rd_addr    <= '0;
                issued     <= '0;
                padded_cnt <= '0;
            end
            if (state == S_PASS_END && !last_pass) begin
                pass_idx <= pass_idx + 3'd1;
            end
            if (state == S_DONE) begin
                pass_idx <= 3'd0;
            end
        end
    end

`ifdef SCHED_PERF_CNT_EN
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            stall_cycles <= '0;
        end else if (state == S_IDLE && start) begin
            stall_cycles <= '0;
        end else if (state == S_RUN &&
                     (pe_stall || (pad_data_req && !pad_data_valid)) &&
                     stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pad_frame_scheduler.sv
// Bench for pad_frame_scheduler: 4x4 image, 4 passes, scoreboard on RAM
// addresses and delivered pixels, stall / busy-start / async-reset scenarios.
module tb_pad_frame_scheduler;

    localparam int W      = 4;
    localparam int H      = 4;
    localparam int NP     = 4;
    localparam int PIX_W  = 24;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 12;
    localparam int NPIX   = W * H;
    localparam int NPAD   = (W + 2) * (H + 2);

    logic              s_clk = 1'b0;
    logic              s_rst;
    logic              start;
    logic              busy;
    logic              done;
    logic              pe_stall;
    logic              ready4data;
    logic              pad_data_req;
    logic              pad_data_valid;
    logic [PIX_W-1:0]  pad_data;
    logic              pad_out_valid;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [PIX_W-1:0]  ram_rd_data;
    logic [2:0]        pass_idx;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0]       stall_cycles;
`endif

    pad_frame_scheduler #(
        .IMG_W(W), .IMG_H(H), .PIX_W(PIX_W),
        .ADDR_W(ADDR_W), .NUM_PASS(NP), .CNT_W(CNT_W)
    ) dut (
        .s_clk          (s_clk),
        .s_rst          (s_rst),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .pe_stall       (pe_stall),
        .ready4data     (ready4data),
        .pad_data_req   (pad_data_req),
        .pad_data_valid (pad_data_valid),
        .pad_data       (pad_data),
        .pad_out_valid  (pad_out_valid),
        .ram_rd_en      (ram_rd_en),
        .ram_rd_addr    (ram_rd_addr),
        .ram_rd_data    (ram_rd_data),
        .pass_idx       (pass_idx)
`ifdef SCHED_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    always #5 s_clk = ~s_clk;

    int compared   = 0;
    int mismatched = 0;
    logic [PIX_W-1:0]  exp_pix[$];
    logic [ADDR_W-1:0] exp_addr[$];
    int pops_pass, beats_pass, exp_pass;
    int done_pulses, reads_total, beats_total;
    bit prev_done;

    function automatic logic [PIX_W-1:0] pix(input logic [ADDR_W-1:0] a);
        return {a[7:0], 6'h2A, a} ^ 24'hA50000;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Image RAM: one-cycle read latency.
    always @(posedge s_clk) begin
        if (ram_rd_en) ram_rd_data <= pix(ram_rd_addr);
    end

    // Padding stage model: requests only when data is offered, and emits at
    // most two padded beats per consumed pixel until the interior is drained.
    initial begin
        pad_data_req  = 1'b0;
        pad_out_valid = 1'b0;
        forever begin
            @(posedge s_clk);
            #1;
            pad_data_req  = pad_data_valid;
            pad_out_valid = busy &&
                (beats_pass < ((pops_pass == NPIX) ? NPAD : 2 * pops_pass));
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge s_clk);
            if (!s_rst) begin
                if (ram_rd_en) begin
                    reads_total++;
                    if (exp_addr.size() == 0) fail("rd_extra");
                    else check("rd_addr", ram_rd_addr, exp_addr.pop_front());
                end
                if (dut.rd_pend)
                    check("push_full", {63'b0, dut.fifo_count == 2'd2}, 64'd0);
                if (pad_data_req && pad_data_valid && ready4data) begin
                    pops_pass++;
                    if (exp_pix.size() == 0) fail("pix_extra");
                    else check("pix", pad_data, exp_pix.pop_front());
                end
                if (pe_stall) check("r4d_stall", ready4data, 64'd0);
                if (pad_out_valid && ready4data) begin
                    beats_pass++;
                    beats_total++;
                    if (beats_pass == NPAD) begin
                        check("pass_idx", pass_idx, exp_pass);
                        check("pops_at_pass_end", pops_pass, NPIX);
                        exp_pass++;
                        beats_pass = 0;
                        pops_pass  = 0;
                    end
                end
                if (done) begin
                    done_pulses++;
                    check("busy_at_done", busy, 64'd1);
                    check("beats_at_done", beats_total, NP * NPAD);
                end
                if (prev_done) begin
                    check("busy_after_done", busy, 64'd0);
                    check("done_width", done, 64'd0);
                end
                prev_done = done;
            end
        end
    end

    task automatic clk1();
        @(posedge s_clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 64'd0);
        check({tag, "_done"}, done, 64'd0);
        check({tag, "_r4d"}, ready4data, 64'd0);
        check({tag, "_pdv"}, pad_data_valid, 64'd0);
        check({tag, "_rden"}, ram_rd_en, 64'd0);
        check({tag, "_addr"}, ram_rd_addr, 64'd0);
        check({tag, "_pass"}, pass_idx, 64'd0);
    endtask

    task automatic prep_run();
        exp_addr.delete();
        exp_pix.delete();
        for (int p = 0; p < NP; p++) begin
            for (int a = 0; a < NPIX; a++) begin
                exp_addr.push_back(ADDR_W'(a));
                exp_pix.push_back(pix(ADDR_W'(a)));
            end
        end
        exp_pass    = 0;
        pops_pass   = 0;
        beats_pass  = 0;
        done_pulses = 0;
        reads_total = 0;
        beats_total = 0;
        prev_done   = 1'b0;
        start = 1'b1;
        clk1();
        start = 1'b0;
    endtask

    task automatic wait_pops(input int n);
        int k = 0;
        while (pops_pass < n && k < 2000) begin
            clk1();
            k++;
        end
        if (pops_pass < n) fail("timeout_pops");
    endtask

    task automatic wait_pass(input int p);
        int k = 0;
        while (pass_idx != 3'(p) && k < 2000) begin
            clk1();
            k++;
        end
        if (pass_idx != 3'(p)) fail("timeout_pass");
    endtask

    task automatic wait_done_and_check();
        int k = 0;
        while (done_pulses == 0 && k < 3000) begin
            clk1();
            k++;
        end
        if (done_pulses == 0) fail("timeout_done");
`ifdef SCHED_PERF_CNT_EN
        check("stall_cycles", stall_cycles, 64'd7);
`endif
        repeat (4) clk1();
        check("done_pulses", done_pulses, 64'd1);
        check("reads_total", reads_total, NP * NPIX);
        check("addr_left", exp_addr.size(), 64'd0);
        check("pix_left", exp_pix.size(), 64'd0);
        check("pass_idx_idle", pass_idx, 64'd0);
    endtask

    initial begin
        s_rst    = 1'b1;
        start    = 1'b0;
        pe_stall = 1'b0;
        repeat (2) clk1();
        check_reset_outputs("rst");
        s_rst = 1'b0;
        clk1();

        // Run A: 10-cycle stall mid-row, start pulse while busy.
        prep_run();
        wait_pops(6);
        pe_stall = 1'b1;
        repeat (10) clk1();
        check("fifo_full_stall", dut.fifo_count, 64'd2);
        check("pdv_stall", pad_data_valid, 64'd1);
        pe_stall = 1'b0;
        wait_pass(1);
        wait_pops(3);
        start = 1'b1;
        clk1();
        start = 1'b0;
`ifdef SCHED_PERF_CNT_EN
        // Run A stalls for 10 cycles; only the later 7-cycle run is checked.
        wait_pass(0);
        repeat (4) clk1();
        check("done_pulses", done_pulses, 64'd1);
        check("reads_total", reads_total, NP * NPIX);
`else
        wait_done_and_check();
`endif

        // Run B: asynchronous reset in the middle of pass 2.
        prep_run();
        wait_pass(2);
        wait_pops(5);
        @(negedge s_clk);
        #2;
        s_rst = 1'b1;
        #1;
        check_reset_outputs("async");
        #1;
        s_rst = 1'b0;
        repeat (5) clk1();
        check("abort_no_done", done_pulses, 64'd0);
        check("abort_idle", busy, 64'd0);

        // Run C: fresh start from address 0, 7-cycle stall burst.
        prep_run();
        wait_pops(3);
        pe_stall = 1'b1;
        repeat (7) clk1();
        pe_stall = 1'b0;
        wait_done_and_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pad_frame_scheduler.md
Name: pad_frame_scheduler

Overview:
Sequences the feature-padding datapath over whole frames. Reads raw pixels from the on-chip image RAM in raster order, buffers them in a 2-entry prefetch FIFO, and serves them to the padding stage's data request. Gates the padding stage's ready4data from PE back-pressure. Replays the frame NUM_PASS times (one pass per timestep) and signals done.

Parameters:
IMG_W, 32, interior image width in pixels
IMG_H, 32, interior image height in pixels
PIX_W, 24, pixel width (3 channels x QUAN_BITS)
ADDR_W, 10, image RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
NUM_PASS, 4, frame replays per start
CNT_W, 12, padded-output counter width; must satisfy 2^CNT_W > (IMG_W+2)*(IMG_H+2)

Ports:
s_clk  in  1  clock
s_rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; accepted only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last pass completes
pe_stall  in  1  PE input FIFO almost full
ready4data  out  1  to padding stage; = (state==RUN) & ~pe_stall
pad_data_req  in  1  padding stage o_data_in_req
pad_data_valid  out  1  prefetch FIFO non-empty & state==RUN
pad_data  out  PIX_W  prefetch FIFO head
pad_out_valid  in  1  padding stage padding_data_out_valid
ram_rd_en  out  1  image RAM read enable
ram_rd_addr  out  ADDR_W  image RAM read address
ram_rd_data  in  PIX_W  image RAM data, valid exactly 1 cycle after ram_rd_en
pass_idx  out  3  current pass, 0..NUM_PASS-1

Behaviour:
- Reset: state IDLE; busy=0, done=0, ready4data=0, pad_data_valid=0, ram_rd_en=0, ram_rd_addr=0, pass_idx=0. FIFO and all counters cleared. Async reset mid-pass aborts; no done is issued.
- States: IDLE -> (start) PREFETCH -> (FIFO count==2) RUN -> (padded count == (IMG_W+2)*(IMG_H+2) on an accepted beat) PASS_END -> RUN if pass_idx<NUM_PASS-1, else DONE -> IDLE.
- PASS_END lasts one cycle: pass_idx++, read address reset to 0, padded counter reset. The FIFO is not flushed; it must already be empty (all IMG_W*IMG_H pixels consumed). It then refills. The transition is to PREFETCH, not straight to RUN, when the FIFO is not full.
- DONE lasts one cycle with done=1. Then IDLE with pass_idx=0.
- Reads: issue ram_rd_en when (FIFO count + reads in flight) < 2 and reads issued this pass < IMG_W*IMG_H. ram_rd_addr increments after each issue and stops at IMG_W*IMG_H-1. Returned data is pushed one cycle later.
- FIFO pop: pad_data_req & pad_data_valid & ready4data. Push and pop in the same cycle leave the count unchanged. Push to a full FIFO cannot occur by construction; the bench asserts it.
- Padded counter increments on pad_out_valid & ready4data.
- pe_stall: drops ready4data combinationally. No pops and no count changes occur while it is high. Reads continue until the FIFO is full.
- start while busy is ignored.
- Underflow (pad_data_req with FIFO empty in RUN) is legal: no pop, and the padding stage waits.

Optional Feature:
Macro SCHED_PERF_CNT_EN.
- Defined: adds output stall_cycles (32 bits). It counts cycles with state==RUN & (pe_stall | (pad_data_req & ~pad_data_valid)). It clears on start and saturates at all-ones.
- Undefined: the port and logic are absent. All other behaviour is identical.

Decomposition:
- Shared package/header: state encoding (IDLE, PREFETCH, RUN, PASS_END, DONE), and the padded-frame size and interior pixel count derived from IMG_W/IMG_H. These constants are shared with the padding stage.
- One natural sub-module: pad_prefetch_fifo, a 2-entry synchronous FIFO with push, pop, count, head and s_rst.

Test Plan:
- Reset, then start with IMG_W=IMG_H=4, NUM_PASS=1, no stall -> addresses 0..15 issued exactly once; 36 padded beats counted; done pulses once; busy falls the cycle after done.
- NUM_PASS=4 -> pass_idx steps 0,1,2,3; 64 total RAM reads; done pulses only after the 144th padded beat.
- pe_stall held high for 10 cycles mid-row -> ready4data=0 during the stall; FIFO holds 2 entries; no address gaps or duplicates in the pixel sequence delivered.
- Start pulse while busy -> ignored; read count and done timing unchanged.
- Async reset asserted mid-pass 2 -> all outputs return to reset values within the same cycle; a new start begins at address 0, pass_idx 0.
- With SCHED_PERF_CNT_EN, 7-cycle pe_stall burst -> stall_cycles reads 7 at done.
